// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter: per-port FIFOs drained round-robin into a registered
// register-file write stage. Optional forwarding taps under `ifdef WB_ARB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in0_valid,
  input  logic [AW-1:0]   in0_rd,
  input  logic [XLEN-1:0] in0_data,
  output logic            in0_ready,
  input  logic            in1_valid,
  input  logic [AW-1:0]   in1_rd,
  input  logic [XLEN-1:0] in1_data,
  output logic            in1_ready,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write,
`ifdef WB_ARB_FWD_EN
  input  logic [AW-1:0]   fwd_rs1,
  input  logic [AW-1:0]   fwd_rs2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
`endif
  output logic            busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count [2];
  logic [PW-1:0]   wptr  [2];
  logic [PW-1:0]   rptr  [2];
  logic [AW-1:0]   mem_rd   [2][DEPTH];
  logic [XLEN-1:0] mem_data [2][DEPTH];
  logic [AW-1:0]   in_rd   [2];
  logic [XLEN-1:0] in_data [2];
  logic [1:0]      in_valid;
  logic [1:0]      full, empty, store, pop;
  logic            rr, gnt_any, gnt_sel;

  assign in_valid   = {in1_valid, in0_valid};
  assign in_rd[0]   = in0_rd;
  assign in_rd[1]   = in1_rd;
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;

  // Pushes to x0 are handshaken but never stored.
  always_comb begin
    full  = '0;
    empty = '0;
    store = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]  = (count[i] == CW'(DEPTH));
      empty[i] = (count[i] == '0);
      store[i] = in_valid[i] && !full[i] && !flush && (in_rd[i] != '0);
    end
  end

  assign in0_ready = !full[0];
  assign in1_ready = !full[1];

  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    if (!flush) begin
      if (!empty[0] && !empty[1]) begin
        gnt_any = 1'b1;
        gnt_sel = rr;
      end else if (!empty[0]) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b0;
      end else if (!empty[1]) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b1;
      end
    end
  end

  assign pop[0] = gnt_any && !gnt_sel;
  assign pop[1] = gnt_any &&  gnt_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        count[i] <= '0;
        wptr[i]  <= '0;
        rptr[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin
        count[i] <= '0;
        wptr[i]  <= '0;
        rptr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (store[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])   rptr[i] <= rptr[i] + PW'(1);
        count[i] <= count[i] + CW'(store[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (store[i]) begin
        mem_rd[i][wptr[i]]   <= in_rd[i];
        mem_data[i][wptr[i]] <= in_data[i];
      end
    end
  end

  // After any grant the other port becomes preferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr         <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      reg_write  <= 1'b0;
    end else begin
      reg_write <= gnt_any;
      if (gnt_any) begin
        rr         <= ~gnt_sel;
        rd         <= mem_rd[gnt_sel][rptr[gnt_sel]];
        write_data <= mem_data[gnt_sel][rptr[gnt_sel]];
      end
    end
  end

  assign busy = !empty[0] || !empty[1] || reg_write;

`ifdef WB_ARB_FWD_EN
  assign fwd_hit1  = reg_write && (rd == fwd_rs1) && (rd != '0);
  assign fwd_hit2  = reg_write && (rd == fwd_rs2) && (rd != '0);
  assign fwd_data1 = write_data;
  assign fwd_data2 = write_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in0_valid = 1'b0, in1_valid = 1'b0;
  logic [AW-1:0]   in0_rd = '0, in1_rd = '0;
  logic [XLEN-1:0] in0_data = '0, in1_data = '0;
  logic            in0_ready, in1_ready, reg_write, busy;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_data;
`ifdef WB_ARB_FWD_EN
  logic [AW-1:0]   fwd_rs1 = '0, fwd_rs2 = '0;
  logic            fwd_hit1, fwd_hit2;
  logic [XLEN-1:0] fwd_data1, fwd_data2;
`endif

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in0_valid(in0_valid), .in0_rd(in0_rd), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_rd(in1_rd), .in1_data(in1_data), .in1_ready(in1_ready),
    .rd(rd), .write_data(write_data), .reg_write(reg_write),
`ifdef WB_ARB_FWD_EN
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            q0[$], q1[$];
  int              rr_m;
  logic            m_we;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;
  int              total = 0, passed = 0, failed = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    rr_m   = 0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic check_output();
    check("reg_write", reg_write, m_we);
    check("rd", rd, m_rd);
    check("write_data", write_data, m_data);
    check("busy", busy, (q0.size() > 0) || (q1.size() > 0) || m_we);
    check("in0_ready", in0_ready, q0.size() < DEPTH);
    check("in1_ready", in1_ready, q1.size() < DEPTH);
`ifdef WB_ARB_FWD_EN
    check("fwd_hit1", fwd_hit1, m_we && (m_rd == fwd_rs1) && (m_rd != 0));
    check("fwd_hit2", fwd_hit2, m_we && (m_rd == fwd_rs2) && (m_rd != 0));
    check("fwd_data1", fwd_data1, m_data);
    check("fwd_data2", fwd_data2, m_data);
`endif
  endtask

  task automatic apply_stimulus(input logic v0, input logic [AW-1:0] r0, input logic [XLEN-1:0] d0,
                                input logic v1, input logic [AW-1:0] r1, input logic [XLEN-1:0] d1,
                                input logic fl);
    in0_valid = v0; in0_rd = r0; in0_data = d0;
    in1_valid = v1; in1_rd = r1; in1_data = d1;
    flush = fl;
  endtask

  // One clock: decide the model's grant/accepts from pre-edge state, then compare.
  task automatic step();
    bit   rdy0, rdy1, g_any;
    int   g;
    ent_t e;
    rdy0  = q0.size() < DEPTH;
    rdy1  = q1.size() < DEPTH;
    g_any = 0;
    g     = 0;
    if (!flush) begin
      if (q0.size() > 0 && q1.size() > 0) begin g_any = 1; g = rr_m; end
      else if (q0.size() > 0) begin g_any = 1; g = 0; end
      else if (q1.size() > 0) begin g_any = 1; g = 1; end
    end
    @(posedge clk);
    #1;
    if (g_any) begin
      if (g == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      m_rd   = e.rd;
      m_data = e.data;
      rr_m   = 1 - g;
    end
    m_we = g_any;
    if (flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (in0_valid && rdy0 && in0_rd != 0) begin e.rd = in0_rd; e.data = in0_data; q0.push_back(e); end
      if (in1_valid && rdy1 && in1_rd != 0) begin e.rd = in1_rd; e.data = in1_data; q1.push_back(e); end
    end
    check_output();
  endtask

  task automatic idle();
    apply_stimulus(0, '0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    model_reset();
    #2;
    check_output();
    #10 rst = 1'b0;

    $display("[TB] single write");
    apply_stimulus(1, 5'd5, 64'hDEAD, 0, '0, '0, 0);
    step();
    idle();
    step();
    check("single_we", reg_write, 1'b1);
    check("single_rd", rd, 5'd5);
    check("single_data", write_data, 64'hDEAD);
    step();
    check("single_once", reg_write, 1'b0);

    $display("[TB] contention");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, AW'(1 + i), {$urandom, $urandom}, 1, AW'(9 + i), {$urandom, $urandom}, 0);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("[TB] x0 drop");
    apply_stimulus(0, '0, '0, 1, 5'd0, 64'hFF, 0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("x0_no_write", reg_write, 1'b0);
    end

    $display("[TB] flush");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, AW'(3 + i), {$urandom, $urandom}, 1, AW'(20 + i), {$urandom, $urandom}, 0);
      step();
    end
    apply_stimulus(1, 5'd30, 64'h1234, 1, 5'd31, 64'h5678, 1);
    step();
    idle();
    step();
    check("flush_idle_we", reg_write, 1'b0);
    check("flush_idle_busy", busy, 1'b0);
    step();

`ifdef WB_ARB_FWD_EN
    $display("[TB] forwarding");
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd0;
    apply_stimulus(1, 5'd7, 64'h42, 0, '0, '0, 0);
    step();
    idle();
    step();
    check("fwd_dir_hit1", fwd_hit1, 1'b1);
    check("fwd_dir_data1", fwd_data1, 64'h42);
    check("fwd_dir_hit2", fwd_hit2, 1'b0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), {$urandom, $urandom},
                     $urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), {$urandom, $urandom},
                     $urandom_range(0, 15) == 0);
`ifdef WB_ARB_FWD_EN
      fwd_rs1 = AW'($urandom_range(0, 31));
      fwd_rs2 = (i % 2 == 0) ? rd : AW'($urandom_range(0, 31));
`endif
      step();
      if (i == 150) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("midreset_we", reg_write, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_rdy0", in0_ready, 1'b1);
        check("midreset_rdy1", in1_ready, 1'b1);
        #2 rst = 1'b0;
      end
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
